// File: rtl/axi_pkg.sv
// Shared AXI types and helpers for the burst write master.
package axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } wm_state_t;

    localparam int unsigned ERR_CNT_W  = 8;
    localparam int unsigned BEAT_CNT_W = 8;
    localparam int unsigned OST_CNT_W  = 4;

    typedef struct packed {
        logic                 sticky;
        logic [ERR_CNT_W-1:0] count;
    } err_stat_t;

    // Saturating increment for the error counter.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/axi_wbuf_fifo.sv
// Synchronous first-word-fall-through write buffer; head word is always on rdata.
module axi_wbuf_fifo #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/axi_wburst_master.sv
// AXI4 INCR-burst write master: buffers a word stream, issues AW/W bursts,
// tracks outstanding B responses and accumulates error status.
module axi_wburst_master
    import axi_pkg::*;
#(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned BURST_LEN       = 4,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_load,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [DATA_W-1:0]   send_data,
    input  logic                data_valid,
    output logic                data_ready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic                busy,
    output logic                err_sticky,
    output logic [7:0]          err_count
);

    localparam int unsigned STRB_W      = DATA_W / 8;
    localparam int unsigned BURST_BYTES = BURST_LEN * STRB_W;
    localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned AXSIZE      = $clog2(STRB_W);

    wm_state_t               state_q, state_d;
    logic [ADDR_W-1:0]       awaddr_q, awaddr_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    wlast_q, wlast_d;
    logic [BEAT_CNT_W-1:0]   beat_q, beat_d;
    logic [OST_CNT_W-1:0]    ost_q, ost_d;
    logic                    bready_q, bready_d;
    logic                    busy_q, busy_d;
    err_stat_t               err_q, err_d;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic [DATA_W-1:0]       fifo_rdata;
    logic                    push;
    logic                    pop;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    burst_done;

    assign data_ready = !fifo_full && !rst;
    assign push       = data_valid && data_ready;
    assign aw_hs      = awvalid_q && awready;
    assign w_hs       = wvalid_q && wready;
    assign b_hs       = bvalid && bready_q;
    assign pop        = w_hs && !fifo_empty;

    axi_wbuf_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_wbuf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (send_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Burst sequencing, outstanding tracking and error accumulation.
    always_comb begin
        state_d    = state_q;
        awaddr_d   = awaddr_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        wlast_d    = wlast_q;
        beat_d     = beat_q;
        ost_d      = ost_q;
        err_d      = err_q;
        burst_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_load) awaddr_d = base_addr;
                if ((fifo_count >= CNT_W'(BURST_LEN)) &&
                    (ost_q < OST_CNT_W'(MAX_OUTSTANDING))) begin
                    state_d   = ST_ADDR;
                    awvalid_d = 1'b1;
                end
            end
            ST_ADDR: begin
                if (aw_hs) begin
                    state_d   = ST_DATA;
                    awvalid_d = 1'b0;
                    awaddr_d  = awaddr_q + ADDR_W'(BURST_BYTES);
                    wvalid_d  = 1'b1;
                    wlast_d   = (BURST_LEN == 1);
                    beat_d    = '0;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    if (wlast_q) begin
                        state_d    = ST_IDLE;
                        wvalid_d   = 1'b0;
                        wlast_d    = 1'b0;
                        burst_done = 1'b1;
                    end else begin
                        beat_d  = beat_q + BEAT_CNT_W'(1);
                        wlast_d = ((beat_q + BEAT_CNT_W'(1)) == BEAT_CNT_W'(BURST_LEN - 1));
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A completing burst and a returning response cancel out.
        case ({burst_done, b_hs})
            2'b10:   ost_d = ost_q + OST_CNT_W'(1);
            2'b01:   ost_d = ost_q - OST_CNT_W'(1);
            default: ost_d = ost_q;
        endcase

        // Configuration clear takes priority over a coincident bad response.
        if (cfg_load && (state_q == ST_IDLE)) begin
            err_d = '0;
        end else if (b_hs && (resp_t'(bresp) != RESP_OKAY)) begin
            err_d.sticky = 1'b1;
            err_d.count  = sat_inc(err_q.count);
        end

        bready_d = (ost_d != '0);
        busy_d   = (state_d != ST_IDLE) || (ost_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            awaddr_q  <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            beat_q    <= '0;
            ost_q     <= '0;
            bready_q  <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            beat_q    <= beat_d;
            ost_q     <= ost_d;
            bready_q  <= bready_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign awaddr     = awaddr_q;
    assign awlen      = 8'(BURST_LEN - 1);
    assign awsize     = 3'(AXSIZE);
    assign awburst    = BURST_INCR;
    assign awvalid    = awvalid_q;
    assign wdata      = fifo_rdata;
    assign wstrb      = '1;
    assign wlast      = wlast_q;
    assign wvalid     = wvalid_q;
    assign bready     = bready_q;
    assign busy       = busy_q;
    assign err_sticky = err_q.sticky;
    assign err_count  = err_q.count;

endmodule

// File: tb/tb_axi_wburst_master.sv
// Scoreboard bench for axi_wburst_master: expected AW addresses and W beats
// are queued as words are pushed and retired as the DUT hands them out.
module tb_axi_wburst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic [31:0] base_addr;
    logic [31:0] send_data;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        busy;
    logic        err_sticky;
    logic [7:0]  err_count;

    // Narrow-address instance for the wrap case
    logic        w_cfg_load;
    logic [11:0] w_base_addr;
    logic [31:0] w_send_data;
    logic        w_data_valid;
    logic        w_data_ready;
    logic [11:0] w_awaddr;
    logic [7:0]  w_awlen;
    logic [2:0]  w_awsize;
    logic [1:0]  w_awburst;
    logic        w_awvalid;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic        w_wlast;
    logic        w_wvalid;
    logic        w_bready;
    logic        w_busy;
    logic        w_err_sticky;
    logic [7:0]  w_err_count;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] exp_w[$];
    logic [31:0] exp_aw[$];
    logic [31:0] tb_addr = 32'h0;
    int          tb_pending = 0;

    int          mon_beat = 0;
    int          mon_aw_pend = 0;
    int          mon_aw_cnt = 0;
    int          mon_w_cnt = 0;
    bit          stall_q = 1'b0;
    logic [31:0] stall_data;
    logic        stall_last;

    always #5 clk = ~clk;

    axi_wburst_master dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .base_addr(base_addr),
        .send_data(send_data), .data_valid(data_valid), .data_ready(data_ready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wvalid(wvalid), .wready(wready), .bresp(bresp),
        .bvalid(bvalid), .bready(bready), .busy(busy), .err_sticky(err_sticky),
        .err_count(err_count)
    );

    axi_wburst_master #(.ADDR_W(12)) dut_w (
        .clk(clk), .rst(rst), .cfg_load(w_cfg_load), .base_addr(w_base_addr),
        .send_data(w_send_data), .data_valid(w_data_valid), .data_ready(w_data_ready),
        .awaddr(w_awaddr), .awlen(w_awlen), .awsize(w_awsize), .awburst(w_awburst),
        .awvalid(w_awvalid), .awready(awready), .wdata(w_wdata), .wstrb(w_wstrb),
        .wlast(w_wlast), .wvalid(w_wvalid), .wready(wready), .bresp(bresp),
        .bvalid(bvalid), .bready(w_bready), .busy(w_busy), .err_sticky(w_err_sticky),
        .err_count(w_err_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [31:0] b);
        cfg_load  = 1'b1;
        base_addr = b;
        tick();
        cfg_load  = 1'b0;
        tb_addr   = b;
    endtask

    // Push one word and queue the beat (and the burst address once a burst fills).
    task automatic push_word(input logic [31:0] w);
        int n = 0;
        bit ok = 1'b0;
        send_data  = w;
        data_valid = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = data_ready;
            tick();
            n++;
        end
        data_valid = 1'b0;
        if (!ok) begin
            check("push_timeout", 0, 1);
        end else begin
            exp_w.push_back(w);
            tb_pending++;
            if (tb_pending == 4) begin
                exp_aw.push_back(tb_addr);
                tb_addr    = tb_addr + 32'h10;
                tb_pending = 0;
            end
        end
    endtask

    task automatic push_burst(input logic [31:0] first);
        for (int i = 0; i < 4; i++) push_word(first + 32'(i));
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_w.size() != 0 || exp_aw.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("drain_timeout", 0, 1);
        tick();
        tick();
    endtask

    task automatic send_b(input logic [1:0] r);
        int n = 0;
        bit ok = 1'b0;
        bresp  = r;
        bvalid = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = bready;
            tick();
            n++;
        end
        bvalid = 1'b0;
        if (!ok) check("b_timeout", 0, 1);
    endtask

    task automatic wait_wvalid();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wvalid && n < 100);
        if (!wvalid) check("wvalid_timeout", 0, 1);
        tick();
    endtask

    // AW/W monitor for the main instance
    always @(negedge clk) begin
        if (rst) begin
            mon_beat    = 0;
            mon_aw_pend = 0;
            stall_q     = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_wvalid", wvalid, 1);
                check("stall_wdata", wdata, stall_data);
                check("stall_wlast", wlast, stall_last);
            end
            stall_q    = wvalid && !wready;
            stall_data = wdata;
            stall_last = wlast;
            if (wvalid && wready) begin
                mon_w_cnt++;
                check("w_after_aw", mon_aw_pend != 0, 1);
                if (exp_w.size() == 0) check("w_extra", 1, 0);
                else check("wdata", wdata, exp_w.pop_front());
                check("wlast", wlast, mon_beat == 3);
                check("wstrb", wstrb, 4'hF);
                if (mon_beat == 3) begin
                    mon_beat = 0;
                    if (mon_aw_pend > 0) mon_aw_pend--;
                end else begin
                    mon_beat++;
                end
            end
            if (awvalid && awready) begin
                mon_aw_cnt++;
                mon_aw_pend++;
                if (exp_aw.size() == 0) check("aw_extra", 1, 0);
                else check("awaddr", awaddr, exp_aw.pop_front());
                check("awlen", awlen, 3);
                check("awsize", awsize, 2);
                check("awburst", awburst, 1);
            end
        end
    end

    initial begin
        int base_cnt;
        int n;
        rst = 1'b1; cfg_load = 1'b0; base_addr = '0; send_data = '0; data_valid = 1'b0;
        awready = 1'b1; wready = 1'b1; bresp = 2'b00; bvalid = 1'b0;
        w_cfg_load = 1'b0; w_base_addr = '0; w_send_data = '0; w_data_valid = 1'b0;

        // Reset values
        repeat (2) tick();
        @(negedge clk);
        check("rst_data_ready", data_ready, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_wlast", wlast, 0);
        check("rst_bready", bready, 0);
        check("rst_busy", busy, 0);
        check("rst_err_sticky", err_sticky, 0);
        check("rst_err_count", err_count, 0);
        check("rst_awaddr", awaddr, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", data_ready, 1);
        tick();

        // Single burst, one outstanding until B
        cfg(32'h1000);
        push_burst(32'hA0);
        wait_drain();
        repeat (3) tick();
        @(negedge clk);
        check("single_bready", bready, 1);
        check("single_busy", busy, 1);
        tick();
        send_b(2'b00);
        @(negedge clk);
        check("single_b_bready", bready, 0);
        check("single_b_busy", busy, 0);
        check("single_err", err_sticky, 0);
        tick();

        // W backpressure 1-0-0-1
        wready   = 1'b0;
        base_cnt = mon_w_cnt;
        push_burst(32'hB0);
        wait_wvalid();
        for (int i = 0; i < 7; i++) begin
            wready = (i == 1 || i == 2) ? 1'b0 : 1'b1;
            tick();
        end
        wready = 1'b1;
        wait_drain();
        check("bp_pops", mon_w_cnt - base_cnt, 4);
        send_b(2'b00);

        // Outstanding limit
        base_cnt = mon_aw_cnt;
        for (int b = 0; b < 3; b++) push_burst(32'hC0 + 32'(4 * b));
        repeat (40) tick();
        @(negedge clk);
        check("ost_aw_cnt2", mon_aw_cnt - base_cnt, 2);
        check("ost_held", exp_aw.size(), 1);
        check("ost_awvalid", awvalid, 0);
        check("ost_bready", bready, 1);
        tick();
        send_b(2'b00);
        wait_drain();
        check("ost_aw_cnt3", mon_aw_cnt - base_cnt, 3);
        send_b(2'b00);
        send_b(2'b00);
        @(negedge clk);
        check("ost_idle", busy, 0);
        tick();

        // Last W handshake coincides with B handshake
        push_burst(32'hD0);
        wait_drain();
        wready = 1'b0;
        push_burst(32'hD4);
        wait_wvalid();
        wready = 1'b1;
        repeat (3) tick();
        bresp  = 2'b00;
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        @(negedge clk);
        check("simul_bready", bready, 1);
        check("simul_busy", busy, 1);
        tick();
        send_b(2'b00);
        @(negedge clk);
        check("simul_after_b", bready, 0);
        tick();

        // Error responses, then clear
        for (int k = 0; k < 3; k++) begin
            push_burst(32'hE0 + 32'(4 * k));
            wait_drain();
            send_b(2'b10);
        end
        @(negedge clk);
        check("err_sticky", err_sticky, 1);
        check("err_count", err_count, 3);
        tick();
        cfg(32'h2000);
        @(negedge clk);
        check("clr_sticky", err_sticky, 0);
        check("clr_count", err_count, 0);
        tick();

        // cfg_load while AW is waiting must be ignored
        awready = 1'b0;
        push_burst(32'hF0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!awvalid && n < 100);
        check("cfg_addr_awvalid", awvalid, 1);
        tick();
        cfg_load  = 1'b1;
        base_addr = 32'h3000;
        tick();
        cfg_load  = 1'b0;
        awready   = 1'b1;
        wait_drain();
        send_b(2'b00);

        // Clear wins over a coincident bad response
        push_burst(32'hF8);
        wait_drain();
        bresp     = 2'b10;
        bvalid    = 1'b1;
        cfg_load  = 1'b1;
        base_addr = 32'h4000;
        tick();
        bvalid    = 1'b0;
        cfg_load  = 1'b0;
        tb_addr   = 32'h4000;
        @(negedge clk);
        check("clrwin_sticky", err_sticky, 0);
        check("clrwin_count", err_count, 0);
        check("clrwin_bready", bready, 0);
        tick();

        // Address wrap on the 12-bit instance
        w_cfg_load  = 1'b1;
        w_base_addr = 12'hFF0;
        tick();
        w_cfg_load   = 1'b0;
        w_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_send_data = 32'h50 + 32'(i);
            tick();
        end
        w_data_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!w_awvalid && n < 100);
        check("wrap_aw_first", w_awaddr, 12'hFF0);
        tick();
        @(negedge clk);
        check("wrap_aw_next", w_awaddr, 12'h000);
        check("wrap_awvalid", w_awvalid, 0);
        tick();
        bresp  = 2'b00;
        bvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!w_bready && n < 100);
        tick();
        bvalid = 1'b0;
        @(negedge clk);
        check("wrap_idle", w_busy, 0);
        tick();

        // Reset in the middle of a burst
        wready = 1'b0;
        push_burst(32'h60);
        wait_wvalid();
        wready = 1'b1;
        repeat (2) tick();
        rst    = 1'b1;
        wready = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", data_ready, 0);
        tick();
        @(negedge clk);
        check("mid_rst_awvalid", awvalid, 0);
        check("mid_rst_wvalid", wvalid, 0);
        check("mid_rst_wlast", wlast, 0);
        check("mid_rst_bready", bready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_awaddr", awaddr, 0);
        exp_w.delete();
        exp_aw.delete();
        tb_pending = 0;
        tb_addr    = 32'h0;
        tick();
        rst    = 1'b0;
        wready = 1'b1;
        @(negedge clk);
        check("mid_rst_ready_after", data_ready, 1);
        repeat (6) tick();
        @(negedge clk);
        check("mid_rst_dropped", awvalid, 0);
        check("mid_rst_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
